muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide unit: executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU over a fixed number of cycles. Processes one bit per cycle (shift-add multiply, restoring divide) behind a start/ready/valid handshake. Sits beside the single-cycle integer ALU in the execute stage. The core stalls on `ready` and writes `rd` back when `valid` pulses.

---
 rtl/muldiv_seq.sv | 165 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
// Shift-add multiply and restoring divide share one 2W-bit accumulator.
module muldiv_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [INSTR_WIDTH-1:0] operation,
    input  logic [DATA_WIDTH-1:0]  rs1,
    input  logic [DATA_WIDTH-1:0]  rs2,
    output logic                   ready,
    output logic                   valid,
    output logic [DATA_WIDTH-1:0]  rd
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [INSTR_WIDTH-1:0] OP_MUL    = INSTR_WIDTH'(0);
    localparam logic [INSTR_WIDTH-1:0] OP_MULH   = INSTR_WIDTH'(1);
    localparam logic [INSTR_WIDTH-1:0] OP_MULHSU = INSTR_WIDTH'(2);
    localparam logic [INSTR_WIDTH-1:0] OP_MULHU  = INSTR_WIDTH'(3);
    localparam logic [INSTR_WIDTH-1:0] OP_DIV    = INSTR_WIDTH'(4);
    localparam logic [INSTR_WIDTH-1:0] OP_DIVU   = INSTR_WIDTH'(5);
    localparam logic [INSTR_WIDTH-1:0] OP_REM    = INSTR_WIDTH'(6);

    logic [1:0]             state_q, state_d;
    logic [INSTR_WIDTH-1:0] op_q, op_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*W-1:0]         acc_q, acc_d;
    logic [W-1:0]           opb_q, opb_d;
    logic [W-1:0]           rs1_q, rs1_d;
    logic                   neg_q, neg_d;
    logic                   rneg_q, rneg_d;
    logic                   zero_q, zero_d;
    logic                   valid_q, valid_d;
    logic [W-1:0]           rd_q, rd_d;

    logic           sgn1, sgn2, neg1, neg2;
    logic [W-1:0]   mag1, mag2;
    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic           rem_ge;
    logic [W-1:0]   rem_diff;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;
    logic           is_div;

    assign sgn1 = (operation == OP_MULH) || (operation == OP_MULHSU) ||
                  (operation == OP_DIV)  || (operation == OP_REM);
    assign sgn2 = (operation == OP_MULH) || (operation == OP_DIV) ||
                  (operation == OP_REM);
    assign neg1 = sgn1 & rs1[W-1];
    assign neg2 = sgn2 & rs2[W-1];
    assign mag1 = neg1 ? (~rs1 + 1'b1) : rs1;
    assign mag2 = neg2 ? (~rs2 + 1'b1) : rs2;

    // Multiply keeps the multiplier in the low half; divide keeps the
    // dividend there, so both load the same way and opb holds rs2's magnitude.
    assign is_div  = op_q[INSTR_WIDTH-1];
    assign mul_sum = {1'b0, acc_q[2*W-1:W]} +
                     (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});

    assign rem_sh   = acc_q[2*W-1:W-1];
    assign rem_ge   = rem_sh >= {1'b0, opb_q};
    assign rem_diff = rem_sh[W-1:0] - opb_q;

    assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = neg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    assign rem_fix  = rneg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        rs1_d   = rs1_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = operation;
                    acc_d   = {{W{1'b0}}, mag1};
                    opb_d   = mag2;
                    rs1_d   = rs1;
                    neg_d   = neg1 ^ neg2;
                    rneg_d  = neg1;
                    zero_d  = (rs2 == {W{1'b0}});
                    cnt_d   = {CW{1'b0}};
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (is_div) begin
                    if (rem_ge)
                        acc_d = {rem_diff, acc_q[W-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*W-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                case (op_q)
                    OP_MUL:                        rd_d = prod_fix[W-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU:  rd_d = prod_fix[2*W-1:W];
                    OP_DIV, OP_DIVU:
                        rd_d = zero_q ? {W{1'b1}} : quo_fix;
                    default:
                        rd_d = zero_q ? rs1_q : rem_fix;
                endcase
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            rs1_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            rs1_q   <= rs1_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign valid = valid_q;
    assign rd    = rd_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: scoreboard of expected results,
// latency and ready/valid protocol checked by a negedge monitor.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   operation = 3'd0;
    logic [W-1:0] rs1 = '0;
    logic [W-1:0] rs2 = '0;
    logic         ready;
    logic         valid;
    logic [W-1:0] rd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           st_q[$];

    muldiv_seq #(.DATA_WIDTH(W), .INSTR_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
        .rs1(rs1), .rs2(rs2), .ready(ready), .valid(valid), .rd(rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: pop the scoreboard on valid, check latency and ready.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            tag_q.delete();
            st_q.delete();
        end else begin
            if (valid) begin
                if (exp_q.size() == 0 || st_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    chk(tag_q.pop_front(), rd, exp_q.pop_front());
                    chk("latency", W'(cyc), W'(st_q.pop_front() + 33));
                end
            end
            chk("ready", {31'd0, ready}, {31'd0, st_q.size() == 0});
            if (start && ready) st_q.push_back(cyc + 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input string tag, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
        operation = op;
        rs1 = a;
        rs2 = b;
        start = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!valid && n < 100) begin
            tick();
            n++;
        end
        if (!valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        logic [W-1:0]   a, b;
        logic [2*W-1:0] p;

        #12;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_rd", rd, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        issue("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        drain();
        issue("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        drain();
        issue("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        drain();
        issue("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        issue("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        drain();
        issue("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        drain();
        issue("divu", 3'd5, 32'd100, 32'd7, 32'd14);
        drain();
        issue("remu", 3'd7, 32'd100, 32'd7, 32'd2);
        drain();
        issue("divu_zero", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        drain();
        issue("rem_zero", 3'd6, 32'd5, 32'd0, 32'd5);
        drain();
        issue("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        drain();
        issue("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        drain();

        for (int i = 0; i < 4; i++) begin
            a = $urandom();
            b = $urandom_range(1, 32'h00FF_FFFF);
            p = {32'd0, a} * {32'd0, b};
            issue("rnd_mulhu", 3'd3, a, b, p[2*W-1:W]);
            drain();
            issue("rnd_divu", 3'd5, a, b, a / b);
            drain();
            issue("rnd_remu", 3'd7, a, b, a % b);
            drain();
        end

        issue("busy_ign", 3'd5, 32'd1000, 32'd10, 32'd100);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            operation = 3'd0;
            rs1 = $urandom();
            rs2 = $urandom();
            tick();
        end
        start = 1'b0;
        drain();

        issue("b2b_first", 3'd0, 32'd6, 32'd7, 32'd42);
        wait_valid();
        issue("b2b_second", 3'd7, 32'd50, 32'd8, 32'd2);
        chk("b2b_valid_drop", {31'd0, valid}, 32'd0);
        drain();

        issue("aborted", 3'd4, 32'd1000, 32'd3, 32'd333);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_rd", rd, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        issue("post_rst", 3'd5, 32'd81, 32'd9, 32'd9);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
